// File: rtl/sram_write_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_write_buffer_if
//  Description : Bundles the upstream (cache controller) request bus and the
//                downstream (SRAM controller) bus of the posted-write buffer.
//                slave  - view taken by sram_write_buffer
//                master - view taken by the surrounding environment
//  Signals     : wr_req/rd_req/address/wdata  upstream request
//                ready/rdata                  upstream completion
//                sram_wr_en/sram_rd_en        SRAM request enables
//                sram_address/sram_wdata      SRAM request payload
//                sram_ready/sram_rdata        SRAM completion
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_write_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              wr_req;
   logic              rd_req;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic [63:0]       rdata;

   logic              sram_wr_en;
   logic              sram_rd_en;
   logic [ADDR_W-1:0] sram_address;
   logic [DATA_W-1:0] sram_wdata;
   logic              sram_ready;
   logic [63:0]       sram_rdata;

   modport slave (
      input  wr_req, rd_req, address, wdata, sram_ready, sram_rdata,
      output ready, rdata, sram_wr_en, sram_rd_en, sram_address, sram_wdata
   );

   modport master (
      output wr_req, rd_req, address, wdata, sram_ready, sram_rdata,
      input  ready, rdata, sram_wr_en, sram_rd_en, sram_address, sram_wdata
   );
endinterface
`default_nettype wire

// File: rtl/sram_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_write_buffer
//  Description : Posted-write FIFO between the data-cache controller and the
//                SRAM controller. Writes are accepted in one cycle and drain
//                to SRAM in order; a read waits until the buffer is empty so
//                it can never overtake a pending write.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                bus (slave)     upstream request bus + SRAM controller bus
//                full, empty     occupancy flags (from registered count)
//                count           current number of buffered writes
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  wire                        clk,
   input  wire                        rst,
   sram_write_buffer_if.slave         bus,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_FULL_COUNT = (c_PTR_W + 1)'(DEPTH);
   localparam logic [c_PTR_W:0]   c_CNT_ONE    = (c_PTR_W + 1)'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_GAP   = 2'd2,
      ST_READ  = 2'd3
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_mem_addr [DEPTH];
   logic [DATA_W-1:0]   r_mem_data [DEPTH];
   logic [c_PTR_W-1:0]  r_head;
   logic [c_PTR_W-1:0]  r_tail;
   logic [c_PTR_W:0]    r_count;

   logic                r_sram_wr_en;
   logic                r_sram_rd_en;
   logic [ADDR_W-1:0]   r_sram_address;
   logic [DATA_W-1:0]   r_sram_wdata;
   logic [63:0]         r_rdata;
   logic                r_rd_done;

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;

   // Full is taken from the registered count, so a pop in the same cycle
   // does not open a slot for a push until the following cycle.
   assign w_full  = (r_count == c_FULL_COUNT);
   assign w_empty = (r_count == '0);
   assign w_push  = bus.wr_req & ~w_full & (r_state != ST_READ);
   assign w_pop   = (r_state == ST_WRITE) & bus.sram_ready;

   // Write completion is combinational (same cycle); read completion is the
   // registered pulse raised the cycle after sram_ready. The two cannot
   // legitimately coincide because upstream holds only one request at a time.
   assign bus.ready        = w_push | r_rd_done;
   assign bus.rdata        = r_rdata;
   assign bus.sram_wr_en   = r_sram_wr_en;
   assign bus.sram_rd_en   = r_sram_rd_en;
   assign bus.sram_address = r_sram_address;
   assign bus.sram_wdata   = r_sram_wdata;

   assign full  = w_full;
   assign empty = w_empty;
   assign count = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_sram_wr_en   <= 1'b0;
         r_sram_rd_en   <= 1'b0;
         r_sram_address <= '0;
         r_sram_wdata   <= '0;
         r_rdata        <= '0;
         r_rd_done      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_addr[i] <= '0;
            r_mem_data[i] <= '0;
         end
      end else begin
         r_rd_done <= 1'b0;

         if (w_push) begin
            r_mem_addr[r_tail] <= bus.address;
            r_mem_data[r_tail] <= bus.wdata;
            r_tail             <= r_tail + c_PTR_ONE;
         end

         if (w_pop) begin
            r_head <= r_head + c_PTR_ONE;
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase

         case (r_state)
            ST_IDLE: begin
               // Buffered writes always go first; this is what keeps a read
               // from bypassing any older (or newly arriving) write.
               if (!w_empty) begin
                  r_state        <= ST_WRITE;
                  r_sram_wr_en   <= 1'b1;
                  r_sram_address <= r_mem_addr[r_head];
                  r_sram_wdata   <= r_mem_data[r_head];
               end else if (bus.rd_req) begin
                  r_state        <= ST_READ;
                  r_sram_rd_en   <= 1'b1;
                  r_sram_address <= bus.address;
               end
            end

            ST_WRITE: begin
               if (bus.sram_ready) begin
                  r_state      <= ST_GAP;
                  r_sram_wr_en <= 1'b0;
               end
            end

            // One idle cycle so the SRAM controller always sees its enable
            // drop between back-to-back transactions.
            ST_GAP: begin
               r_state <= ST_IDLE;
            end

            ST_READ: begin
               if (bus.sram_ready) begin
                  r_state      <= ST_GAP;
                  r_sram_rd_en <= 1'b0;
                  r_rdata      <= bus.sram_rdata;
                  r_rd_done    <= 1'b1;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_write_buffer
//  Description : Directed bench for sram_write_buffer. Plays the roles of the
//                cache controller and the SRAM controller, and compares the
//                buffer's outputs against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_write_buffer;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   full;
   logic                   empty;
   logic [$clog2(DEPTH):0] count;

   int vectors     = 0;
   int miscompares = 0;

   sram_write_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sram_write_buffer #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle write from the cache side; ready must be seen immediately.
   task automatic push(input string tag, input logic [31:0] a, input logic [31:0] d);
      bus.wr_req  = 1'b1;
      bus.address = a;
      bus.wdata   = d;
      #1;
      chk({tag, " ready"}, 64'(bus.ready), 64'd1);
      step();
      bus.wr_req = 1'b0;
   endtask

   // Wait (bounded) for the next SRAM write, check its payload, complete it.
   task automatic drain_one(input string tag, input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 0;
      while (!bus.sram_wr_en && n < 20) begin
         step();
         n++;
      end
      chk({tag, " wr_en"}, 64'(bus.sram_wr_en), 64'd1);
      chk({tag, " addr"},  64'(bus.sram_address), 64'(a));
      chk({tag, " data"},  64'(bus.sram_wdata), 64'(d));
      bus.sram_ready = 1'b1;
      step();
      bus.sram_ready = 1'b0;
      chk({tag, " gap wr_en"}, 64'(bus.sram_wr_en), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      rst            = 1'b1;
      bus.wr_req     = 1'b0;
      bus.rd_req     = 1'b0;
      bus.address    = '0;
      bus.wdata      = '0;
      bus.sram_ready = 1'b0;
      bus.sram_rdata = '0;
      step();
      step();
      rst = 1'b0;

      // ---- reset state ----
      chk("rst ready",  64'(bus.ready), 64'd0);
      chk("rst rdata",  bus.rdata, 64'd0);
      chk("rst wr_en",  64'(bus.sram_wr_en), 64'd0);
      chk("rst rd_en",  64'(bus.sram_rd_en), 64'd0);
      chk("rst saddr",  64'(bus.sram_address), 64'd0);
      chk("rst swdata", 64'(bus.sram_wdata), 64'd0);
      chk("rst full",   64'(full), 64'd0);
      chk("rst empty",  64'(empty), 64'd1);
      chk("rst count",  64'(count), 64'd0);

      // ---- single write into an empty buffer ----
      push("w1", 32'h10, 32'hDEADBEEF);
      chk("w1 count", 64'(count), 64'd1);
      chk("w1 wr_en idle", 64'(bus.sram_wr_en), 64'd0);
      step();
      chk("w1 wr_en", 64'(bus.sram_wr_en), 64'd1);
      chk("w1 addr",  64'(bus.sram_address), 64'h10);
      chk("w1 data",  64'(bus.sram_wdata), 64'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("w1 hold wr_en", 64'(bus.sram_wr_en), 64'd1);
         chk("w1 hold addr",  64'(bus.sram_address), 64'h10);
      end
      bus.sram_ready = 1'b1;
      step();
      bus.sram_ready = 1'b0;
      chk("w1 pop count", 64'(count), 64'd0);
      chk("w1 pop empty", 64'(empty), 64'd1);
      chk("w1 gap wr_en", 64'(bus.sram_wr_en), 64'd0);
      step();
      chk("w1 idle wr_en", 64'(bus.sram_wr_en), 64'd0);

      // ---- fill and stall ----
      push("fA0", 32'h100, 32'hA0);
      push("fA1", 32'h104, 32'hA1);
      push("fA2", 32'h108, 32'hA2);
      push("fA3", 32'h10C, 32'hA3);
      chk("fill full",  64'(full), 64'd1);
      chk("fill count", 64'(count), 64'd4);
      bus.wr_req  = 1'b1;
      bus.address = 32'h110;
      bus.wdata   = 32'hA4;
      #1;
      chk("fA4 stall ready", 64'(bus.ready), 64'd0);
      step();
      step();
      chk("fA4 stall ready2", 64'(bus.ready), 64'd0);
      chk("fill head addr", 64'(bus.sram_address), 64'h100);
      chk("fill head data", 64'(bus.sram_wdata), 64'hA0);
      bus.sram_ready = 1'b1;
      #1;
      chk("fA4 refused on pop", 64'(bus.ready), 64'd0);
      step();
      bus.sram_ready = 1'b0;
      chk("fill after pop count", 64'(count), 64'd3);
      chk("fA4 accepted ready", 64'(bus.ready), 64'd1);
      step();
      bus.wr_req = 1'b0;
      chk("fill refill count", 64'(count), 64'd4);
      drain_one("dA1", 32'h104, 32'hA1);
      drain_one("dA2", 32'h108, 32'hA2);
      drain_one("dA3", 32'h10C, 32'hA3);
      drain_one("dA4", 32'h110, 32'hA4);
      chk("fill drained", 64'(empty), 64'd1);

      // ---- read behind writes ----
      push("rW0", 32'h40, 32'h11);
      push("rW1", 32'h44, 32'h22);
      bus.rd_req  = 1'b1;
      bus.address = 32'h20;
      #1;
      chk("rd early rd_en", 64'(bus.sram_rd_en), 64'd0);
      chk("rd early ready", 64'(bus.ready), 64'd0);
      drain_one("rW0", 32'h40, 32'h11);
      chk("rd mid rd_en", 64'(bus.sram_rd_en), 64'd0);
      drain_one("rW1", 32'h44, 32'h22);
      n = 0;
      while (!bus.sram_rd_en && n < 20) begin
         step();
         n++;
      end
      chk("rd rd_en",  64'(bus.sram_rd_en), 64'd1);
      chk("rd wr_en",  64'(bus.sram_wr_en), 64'd0);
      chk("rd addr",   64'(bus.sram_address), 64'h20);
      chk("rd empty",  64'(empty), 64'd1);
      bus.wr_req = 1'b1;
      bus.wdata  = 32'h99;
      #1;
      chk("rd blocks write", 64'(bus.ready), 64'd0);
      bus.wr_req = 1'b0;
      bus.sram_rdata = 64'h0123456789ABCDEF;
      bus.sram_ready = 1'b1;
      #1;
      chk("rd ready early", 64'(bus.ready), 64'd0);
      step();
      bus.sram_ready = 1'b0;
      bus.sram_rdata = '0;
      chk("rd ready pulse", 64'(bus.ready), 64'd1);
      chk("rd rdata", bus.rdata, 64'h0123456789ABCDEF);
      chk("rd rd_en drop", 64'(bus.sram_rd_en), 64'd0);
      bus.rd_req = 1'b0;
      step();
      chk("rd ready single", 64'(bus.ready), 64'd0);
      chk("rd rdata hold", bus.rdata, 64'h0123456789ABCDEF);

      // ---- wrap-around: 7 writes interleaved with drains ----
      push("B0", 32'h1000, 32'hB0);
      push("B1", 32'h1004, 32'hB1);
      push("B2", 32'h1008, 32'hB2);
      drain_one("B0", 32'h1000, 32'hB0);
      drain_one("B1", 32'h1004, 32'hB1);
      chk("wrap count1", 64'(count), 64'd1);
      push("B3", 32'h100C, 32'hB3);
      push("B4", 32'h1010, 32'hB4);
      push("B5", 32'h1014, 32'hB5);
      chk("wrap full",   64'(full), 64'd1);
      chk("wrap count4", 64'(count), 64'd4);
      drain_one("B2", 32'h1008, 32'hB2);
      drain_one("B3", 32'h100C, 32'hB3);
      drain_one("B4", 32'h1010, 32'hB4);
      push("B6", 32'h1018, 32'hB6);
      chk("wrap count2", 64'(count), 64'd2);
      drain_one("B5", 32'h1014, 32'hB5);
      drain_one("B6", 32'h1018, 32'hB6);
      chk("wrap empty", 64'(empty), 64'd1);

      // ---- simultaneous push and pop ----
      push("C0", 32'h200, 32'hC0);
      push("C1", 32'h204, 32'hC1);
      n = 0;
      while (!bus.sram_wr_en && n < 20) begin
         step();
         n++;
      end
      chk("pp count before", 64'(count), 64'd2);
      chk("pp head addr", 64'(bus.sram_address), 64'h200);
      bus.wr_req     = 1'b1;
      bus.address    = 32'h208;
      bus.wdata      = 32'hC2;
      bus.sram_ready = 1'b1;
      #1;
      chk("pp ready", 64'(bus.ready), 64'd1);
      step();
      bus.wr_req     = 1'b0;
      bus.sram_ready = 1'b0;
      chk("pp count after", 64'(count), 64'd2);
      drain_one("C1", 32'h204, 32'hC1);
      drain_one("C2", 32'h208, 32'hC2);
      chk("pp empty", 64'(empty), 64'd1);

      // ---- reset mid-drain ----
      push("D0", 32'h300, 32'hD0);
      push("D1", 32'h304, 32'hD1);
      push("D2", 32'h308, 32'hD2);
      n = 0;
      while (!bus.sram_wr_en && n < 20) begin
         step();
         n++;
      end
      chk("rm wr_en", 64'(bus.sram_wr_en), 64'd1);
      chk("rm count", 64'(count), 64'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rm wr_en off", 64'(bus.sram_wr_en), 64'd0);
      chk("rm empty",     64'(empty), 64'd1);
      chk("rm count0",    64'(count), 64'd0);
      chk("rm full",      64'(full), 64'd0);
      chk("rm rdata",     bus.rdata, 64'd0);
      step();
      chk("rm idle wr_en", 64'(bus.sram_wr_en), 64'd0);
      push("E0", 32'h400, 32'hE0);
      drain_one("E0", 32'h400, 32'hE0);
      chk("rm final empty", 64'(empty), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_write_buffer.md
Name: sram_write_buffer

Overview:
- Posted-write FIFO between the data-cache controller and the SRAM controller.
- Cache write-throughs complete in one cycle, without waiting out the multi-cycle SRAM write handshake; queued writes then drain to SRAM in order.
- Reads are held until the buffer is empty, so they never bypass a pending write and no forwarding is needed.

Parameters:
- DEPTH, 4, number of buffered write entries (power of two, at least 2).
- ADDR_W, 32, address width.
- DATA_W, 32, write data width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- wr_req  input  1  upstream write request, held until ready.
- rd_req  input  1  upstream read request, held until ready.
- address  input  ADDR_W  upstream request address.
- wdata  input  DATA_W  upstream write data.
- ready  output  1  upstream request complete (one-cycle pulse).
- rdata  output  64  read data, valid while ready is high after a read.
- sram_wr_en  output  1  write request to the SRAM controller.
- sram_rd_en  output  1  read request to the SRAM controller.
- sram_address  output  ADDR_W  address to the SRAM controller.
- sram_wdata  output  DATA_W  write data to the SRAM controller.
- sram_ready  input  1  SRAM controller done pulse (one cycle).
- sram_rdata  input  64  SRAM controller read data, valid with sram_ready.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE, pointers 0, count 0, entries cleared. Outputs after reset: ready 0, rdata 0, sram_wr_en 0, sram_rd_en 0, sram_address 0, sram_wdata 0, full 0, empty 1.
- Reset mid-operation: reset at any point discards all entries and aborts any in-flight SRAM access.
- Storage: DEPTH entries of {address, wdata}. Head (read) and tail (write) pointers wrap modulo DEPTH.
- Write accept rule: ready = wr_req & ~full & (state != READ), combinational, in the same cycle. The entry is pushed at that clock edge.
- Full is evaluated on registered count. A push is refused when full, even if a pop happens in the same cycle.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Priority: wr_req and rd_req together is an upstream protocol error. The write wins; the read waits.
- IDLE state:
  - If ~empty: go to WRITE and present the head entry.
  - Else if rd_req: go to READ and present the address.
  - Otherwise stay in IDLE.
- WRITE state:
  - sram_wr_en = 1; sram_address and sram_wdata come from the head entry and stay stable.
  - On sram_ready: pop the head and go to GAP.
- GAP state (one cycle): all SRAM enables 0, then return to IDLE. This guarantees an enable drop between consecutive SRAM transactions.
- READ state:
  - sram_rd_en = 1; sram_address = address.
  - On sram_ready: register rdata <= sram_rdata and go to GAP.
  - ready pulses for exactly one cycle, the cycle after sram_ready, registered.
  - rdata holds its value until the next read completes.
- Read ordering: a read arriving with a non-empty buffer waits until every older entry has drained. Writes arriving during that drain are accepted and also drain before the read (write priority in IDLE).
- Read latency from an empty IDLE state: SRAM latency + 1 cycle.
- Pending read blocks writes: once in READ, wr_req gets no ready until the read completes.
- Pointer wrap: a DEPTH-th push wraps tail to 0. FIFO order is preserved across the wrap.

Test Plan:
- Single write, empty buffer:
  - Stimulus: wr_req with address 0x10, wdata 0xDEADBEEF.
  - Response: ready the same cycle; count goes to 1; the next cycle sram_wr_en = 1 with address 0x10.
  - Then: sram_ready after 5 cycles pops the entry, count = 0, one GAP cycle, IDLE.
- Fill and stall:
  - Stimulus: 4 back-to-back writes (A0..A3) with sram_ready withheld, then a 5th write.
  - Response: full = 1; the 5th gets no ready until the first sram_ready pop frees space, then it is accepted.
  - Then: SRAM sees the writes in the order A0, A1, A2, A3, A4.
- Read behind writes:
  - Stimulus: 2 writes, then rd_req with address 0x20.
  - Response: both writes are issued first; sram_rd_en asserts only after empty.
  - Then: with sram_rdata = 0x0123456789ABCDEF, rdata shows that value and ready pulses exactly one cycle.
- Wrap-around:
  - Stimulus: 7 writes interleaved with drains.
  - Response: tail pointer wraps; the data order checked at SRAM matches issue order; count never exceeds 4.
- Reset mid-drain:
  - Stimulus: 3 entries buffered, sram_wr_en high, rst asserted for 1 cycle.
  - Response: next cycle sram_wr_en = 0, empty = 1, count = 0, state IDLE; a new write then issues normally.
- Simultaneous push/pop:
  - Stimulus: count = 2, sram_ready pops in the same cycle that wr_req is accepted.
  - Response: count stays 2 and the head advances.
